lsu_rmw: RTL

Load/store unit sitting between the core's execute stage and `data_mem`. It is the initiator side of the `data_mem` interface: it issues word-aligned requests, and it extracts and sign-extends or zero-extends byte and halfword loads. Because `data_mem` has no byte enables, byte and halfword stores are done as read-modify-write. The core is stalled until each access completes.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/lsu_align.sv | 27 ++
 rtl/lsu_rmw.sv | 95 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store size codes and request legality helpers.
package riscv_pkg;
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  function automatic logic size_legal(input logic [2:0] s, input logic we);
    return (s inside {LDST_B, LDST_H, LDST_W}) || (!we && (s inside {LDST_BU, LDST_HU}));
  endfunction

  // s[1:0] == 01 covers both H and HU.
  function automatic logic misaligned(input logic [2:0] s, input logic [1:0] a);
    return (s[1:0] == 2'b01 && a[0]) || (s == LDST_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: extracts sub-word loads and merges sub-word stores into a read word.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [31:0] wd_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask, data;

  always_comb begin
    b = 8'(rd_i >> {off_i, 3'b000});
    h = off_i[1] ? rd_i[31:16] : rd_i[15:0];
    ld_o = size_i == LDST_B  ? {{24{b[7]}}, b} :
           size_i == LDST_BU ? {24'b0, b} :
           size_i == LDST_H  ? {{16{h[15]}}, h} :
           size_i == LDST_HU ? {16'b0, h} : rd_i;
    mask = size_i[0] ? (off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'h0000_00FF << {off_i, 3'b000};
    data = size_i[0] ? {2{wd_i[15:0]}} : {4{wd_i[7:0]}};
    st_o = (rd_i & ~mask) | (data & mask);
  end
endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit with sub-word extraction and read-modify-write stores.
module lsu_rmw
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);
  typedef enum logic [1:0] {IDLE, LOAD, RMW} lsu_state_t;

  lsu_state_t  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] ld, st;
  logic        bad, is_sw;

  lsu_align u_align (
    .rd_i  (mem_rd_i),
    .wd_i  (core_wd_i),
    .off_i (off_q),
    .size_i(size_q),
    .ld_o  (ld),
    .st_o  (st)
  );

  assign bad   = !size_legal(core_size_i, core_we_i) || misaligned(core_size_i, core_addr_i[1:0]);
  assign is_sw = core_we_i && core_size_i == LDST_W;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
    end

  // Reset gates every output so an aborted RMW can never write.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    core_rd_o    = '0;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = {core_addr_i[31:2], 2'b00};
    mem_wd_o     = core_wd_i;
    if (rst_i || (state_q == IDLE && !core_req_i)) begin
      mem_addr_o = '0;
      mem_wd_o   = '0;
    end else begin
      case (state_q)
        IDLE:
          if (bad) core_err_o = 1'b1;
          else begin
            mem_req_o    = 1'b1;
            mem_we_o     = is_sw;
            core_stall_o = !is_sw;
            if (!is_sw) begin
              off_d   = core_addr_i[1:0];
              size_d  = core_size_i;
              state_d = core_we_i ? RMW : LOAD;
            end
          end
        LOAD: begin
          core_rd_o = ld;
          state_d   = IDLE;
        end
        RMW: begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
          mem_wd_o  = st;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
